microwave_sequencer: RTL and testbench

Control sequencer for the microwave oven. It owns the cook-time register (three BCD digits M:ST:SO), keypad digit entry, start/stop/clear handling, the door interlock and the magnetron enable. It produces the 1 Hz countdown from the system clock. Its BCD digit outputs feed the seven-segment decoders; `mag_on` drives the magnetron.

---
 rtl/microwave_sequencer.sv | 155 +++++++++++++++
 tb/tb_microwave_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/microwave_sequencer.sv
// Microwave oven control sequencer: BCD cook-time entry, start/stop/clear,
// door interlock, 1 Hz countdown prescaler and registered magnetron enable.
module microwave_sequencer #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       mag_on,
    output logic       done
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {S_IDLE, S_COOK, S_PAUSE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    mins_q, mins_d, tens_q, tens_d, ones_q, ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          mag_q, mag_d, done_q, done_d;
    logic          start_prev_q, stop_prev_q, clear_prev_q, key_prev_q;

    logic       key_any, key_onehot, key_ev, start_ev, stop_ev, clear_ev;
    logic       cook, tick, time_nz;
    logic [3:0] key_digit, dec_mins, dec_tens, dec_ones;
    logic       dec_zero;

    assign key_any    = |keypad;
    assign key_onehot = key_any && ((keypad & (keypad - 10'd1)) == 10'd0);
    assign key_ev     = key_any && !key_prev_q;
    assign start_ev   = !startn && start_prev_q;
    assign stop_ev    = !stopn && stop_prev_q;
    assign clear_ev   = !clearn && clear_prev_q;

    assign cook    = (state_q == S_COOK);
    assign tick    = cook && (presc_q == PRESC_LAST);
    assign time_nz = (mins_q != 4'd0) || (tens_q != 4'd0) || (ones_q != 4'd0);

    always_comb begin
        key_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) key_digit = 4'(i);
        end
    end

    // Borrow chain for one second; digits need not be normalised (e.g. 1:79).
    always_comb begin
        dec_mins = mins_q;
        dec_tens = tens_q;
        dec_ones = ones_q;
        if (ones_q != 4'd0) begin
            dec_ones = ones_q - 4'd1;
        end else if (tens_q != 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = tens_q - 4'd1;
        end else begin
            dec_ones = 4'd9;
            dec_tens = 4'd5;
            dec_mins = mins_q - 4'd1;
        end
    end
    assign dec_zero = (dec_mins == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);

    always_comb begin
        state_d = state_q;
        mins_d  = mins_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;
        done_d  = done_q;
        if (key_ev || start_ev || stop_ev || clear_ev || !door_closed) done_d = 1'b0;

        if (clear_ev) begin
            state_d = S_IDLE;
            mins_d  = 4'd0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            presc_d = '0;
        end else if (cook && (!door_closed || stop_ev)) begin
            // Pause wins over a coincident tick, but that second is still consumed.
            state_d = S_PAUSE;
            presc_d = '0;
            if (tick) begin
                mins_d = dec_mins;
                tens_d = dec_tens;
                ones_d = dec_ones;
            end
        end else if (start_ev && !cook && door_closed && time_nz) begin
            state_d = S_COOK;
            presc_d = '0;
        end else if (key_ev && key_onehot && state_q == S_IDLE) begin
            mins_d = tens_q;
            tens_d = ones_q;
            ones_d = key_digit;
        end else if (cook) begin
            if (tick) begin
                presc_d = '0;
                mins_d  = dec_mins;
                tens_d  = dec_tens;
                ones_d  = dec_ones;
                if (dec_zero) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = '0;
        end

        mag_d = (state_d == S_COOK) && door_closed;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mins_q       <= 4'd0;
            tens_q       <= 4'd0;
            ones_q       <= 4'd0;
            presc_q      <= '0;
            mag_q        <= 1'b0;
            done_q       <= 1'b0;
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            clear_prev_q <= 1'b1;
            key_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mins_q       <= mins_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            presc_q      <= presc_d;
            mag_q        <= mag_d;
            done_q       <= done_d;
            start_prev_q <= startn;
            stop_prev_q  <= stopn;
            clear_prev_q <= clearn;
            key_prev_q   <= key_any;
        end
    end

    assign mins     = mins_q;
    assign sec_tens = tens_q;
    assign sec_ones = ones_q;
    assign mag_on   = mag_q;
    assign done     = done_q;
endmodule

// File: tb/tb_microwave_sequencer.sv
// Self-checking bench for microwave_sequencer with a one-second prescale of 4 cycles.
module tb_microwave_sequencer;
    localparam int TPS = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] keypad;
    logic       startn, stopn, clearn, door_closed;
    logic [3:0] mins, sec_tens, sec_ones;
    logic       mag_on, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [13:0] exp;
    } sb_entry_t;
    sb_entry_t sb_q[$];

    microwave_sequencer #(.TICKS_PER_SEC(TPS)) dut (
        .clock(clock), .reset(reset), .keypad(keypad),
        .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed),
        .mins(mins), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .mag_on(mag_on), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // Expected {mins, sec_tens, sec_ones, mag_on, done}
    task automatic sb_push(input string tag, input logic [3:0] m, input logic [3:0] t,
                           input logic [3:0] o, input logic mag, input logic dn);
        sb_entry_t e;
        e.tag = tag;
        e.exp = {m, t, o, mag, dn};
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check();
        sb_entry_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, {18'd0, mins, sec_tens, sec_ones, mag_on, done}, {18'd0, e.exp});
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press_key(input int d);
        keypad = 10'd1 << d;
        step(1);
        keypad = 10'd0;
        step(1);
    endtask

    task automatic press_start();
        startn = 1'b0; step(1); startn = 1'b1; step(1);
    endtask

    task automatic press_stop();
        stopn = 1'b0; step(1); stopn = 1'b1; step(1);
    endtask

    task automatic press_clear();
        clearn = 1'b0; step(1); clearn = 1'b1; step(1);
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (!done && c < 5000) begin
            step(1);
            c++;
        end
    endtask

    int cyc;

    initial begin
        reset = 1'b1; keypad = 10'd0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b0;
        step(2);
        reset = 1'b0;
        sb_push("reset", 0, 0, 0, 0, 0); sb_pop_check();

        // Entry with door open, start refused, then a full cook.
        press_key(3); press_key(5); press_key(9);
        sb_push("entry_359", 3, 5, 9, 0, 0); sb_pop_check();
        press_start();
        sb_push("start_door_open", 3, 5, 9, 0, 0); sb_pop_check();
        door_closed = 1'b1; step(1);
        press_start();
        sb_push("start_359", 3, 5, 9, 1, 0); sb_pop_check();
        wait_done(cyc);
        check_val("cook_359_cycles", cyc + 1, 239 * TPS);
        sb_push("done_359", 0, 0, 0, 0, 1); sb_pop_check();

        // Door-open pause and resume.
        press_key(2);
        sb_push("key_clears_done", 0, 0, 2, 0, 0); sb_pop_check();
        press_key(4); press_key(5);
        press_start();
        step(30 * TPS - 1);
        sb_push("after_30s_215", 2, 1, 5, 1, 0); sb_pop_check();
        door_closed = 1'b0; step(1);
        sb_push("door_open_pause", 2, 1, 5, 0, 0); sb_pop_check();
        step(10);
        press_start();
        sb_push("frozen_start_ignored", 2, 1, 5, 0, 0); sb_pop_check();
        door_closed = 1'b1; step(1);
        press_start();
        wait_done(cyc);
        check_val("resume_215_cycles", cyc + 1, 135 * TPS);
        sb_push("done_215", 0, 0, 0, 0, 1); sb_pop_check();

        // Stop pause, keys ignored while paused.
        press_key(4); press_key(4); press_key(5);
        press_start();
        step(30 * TPS - 1);
        press_stop();
        sb_push("stop_pause_415", 4, 1, 5, 0, 0); sb_pop_check();
        press_key(7);
        sb_push("key_in_pause", 4, 1, 5, 0, 0); sb_pop_check();
        press_start();
        wait_done(cyc);
        check_val("resume_415_cycles", cyc + 1, 255 * TPS);

        // Clear mid-cook, then start refused at zero time.
        press_key(2); press_key(4); press_key(5);
        press_start();
        step(30 * TPS - 1);
        press_clear();
        sb_push("clear_mid_cook", 0, 0, 0, 0, 0); sb_pop_check();
        press_start();
        sb_push("start_zero_time", 0, 0, 0, 0, 0); sb_pop_check();

        // Unnormalised 1:79 countdown.
        press_key(1); press_key(7); press_key(9);
        sb_push("entry_179", 1, 7, 9, 0, 0); sb_pop_check();
        press_start();
        step(TPS - 1);
        sb_push("first_dec_178", 1, 7, 8, 1, 0); sb_pop_check();
        step(9 * TPS);
        sb_push("borrow_169", 1, 6, 9, 1, 0); sb_pop_check();
        wait_done(cyc);
        check_val("cook_179_rest_cycles", cyc, 129 * TPS);

        // Two keys together are ignored.
        keypad = (10'd1 << 2) | (10'd1 << 4); step(1);
        keypad = 10'd0; step(1);
        sb_push("two_keys_ignored", 0, 0, 0, 0, 0); sb_pop_check();

        // Held key produces one digit.
        keypad = 10'd1 << 6; step(50);
        keypad = 10'd0; step(1);
        sb_push("held_key_once", 0, 0, 6, 0, 0); sb_pop_check();

        // Clear and start coincide.
        press_key(3);
        startn = 1'b0; clearn = 1'b0; step(1);
        startn = 1'b1; clearn = 1'b1; step(1);
        sb_push("clear_beats_start", 0, 0, 0, 0, 0); sb_pop_check();

        // Reset in the middle of a cook.
        press_key(5);
        press_start();
        step(5);
        sb_push("cook_005_to_004", 0, 0, 4, 1, 0); sb_pop_check();
        reset = 1'b1; step(1);
        sb_push("reset_mid_cook", 0, 0, 0, 0, 0); sb_pop_check();
        reset = 1'b0; step(1);

        check_val("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
